// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, LSB first, centre-sampled.
// Two-flop synchroniser, start-edge detect, registered strobes.
module uart_rx #(
  parameter int CLOCK_HZ     = 1_000_000,
  parameter int BAUD_HZ      = 9_600,
  parameter int CLKS_PER_BIT = CLOCK_HZ / BAUD_HZ
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic          sync1, rx_s, rx_prev;
  logic [1:0]    warm;
  logic          armed;
  logic [CW-1:0] clk_cnt, clk_cnt_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shift, shift_nx;
  logic [7:0]    rx_byte_nx;
  logic          valid_nx, ferr_nx;
  logic          start_det, at_half, at_end;

  // armed only once the real line has been seen high after reset,
  // so a line held low through reset cannot fake a start edge
  assign start_det = armed & rx_prev & ~rx_s;
  assign at_half   = (clk_cnt == HALF_M1);
  assign at_end    = (clk_cnt == LAST);
  assign busy      = (state != IDLE);

  // synchroniser, edge history and line-seen-high arming
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      warm    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sync1   <= serial_rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
      warm    <= {warm[0], 1'b1};
      armed   <= armed | (warm[1] & rx_s);
    end
  end

  // FSM state, counters, shifter and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nx;
      clk_cnt     <= clk_cnt_nx;
      bit_cnt     <= bit_cnt_nx;
      shift       <= shift_nx;
      rx_byte     <= rx_byte_nx;
      rx_valid    <= valid_nx;
      frame_error <= ferr_nx;
    end
  end

  // next state: sample at bit centres, strobe on stop sample
  always_comb begin
    state_nx   = state;
    clk_cnt_nx = clk_cnt;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    rx_byte_nx = rx_byte;
    valid_nx   = 1'b0;
    ferr_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_det) begin
          state_nx   = START;
          clk_cnt_nx = '0;
          bit_cnt_nx = '0;
        end
      end
      START: begin
        if (at_half) begin
          clk_cnt_nx = '0;
          state_nx   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_nx = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (at_end) begin
          clk_cnt_nx = '0;
          shift_nx   = {rx_s, shift[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end else begin
          clk_cnt_nx = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (at_end) begin
          clk_cnt_nx = '0;
          state_nx   = IDLE;
          if (rx_s) begin
            rx_byte_nx = shift;
            valid_nx   = 1'b1;
          end else begin
            ferr_nx = 1'b1;
          end
        end else begin
          clk_cnt_nx = clk_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
